submdl_deser8: RTL and testbench
================================

Name: submdl_deser8

Overview:
Byte assembler that consumes the one-hot 8-phase rotation vector and a serial bit stream, packing one bit per phase into bytes, LSB first. Completed bytes go into a small FIFO with a valid/ready output handshake. The block drives the rotator's stop input back-pressure so the rotator halts between bytes when the FIFO is near full. It tracks frame position and flags overrun and phase errors.

Parameters:
DEPTH, 2, FIFO depth in bytes; legal range 2..16.
FRAME_LEN, 64, bytes per frame; legal range 1..256. The last byte of each frame is tagged.

Ports:
i_CLK  input  1  master clock
i_RST_n  input  1  asynchronous active-low reset
i_CEN_n  input  1  clock enable, active low; gates the sampling/push side only
i_ROT8  input  8  one-hot phase vector from the rotator; bit k = phase k
i_SDATA  input  1  serial data bit, valid on CEN cycles
o_STOP_n  output  1  to the rotator's stop input; low = do not start a new rotation
o_DATA  output  8  FIFO head byte
o_LAST  output  1  FIFO head is the last byte of a frame
o_VALID  output  1  FIFO non-empty
i_READY  input  1  consumer accepts the head when o_VALID=1
i_CLR  input  1  synchronous clear of sticky flags
o_OVR  output  1  sticky: a completed byte was dropped because the FIFO was full
o_PHERR  output  1  sticky: a multi-hot phase vector, or an incomplete byte at phase 7

Behaviour:
- Reset (async, i_RST_n=0):
  - Shift register SR[7:0]=0, bit-seen mask M[6:0]=0, FIFO count=0, read/write pointers=0, frame counter FC=0.
  - o_VALID=0, o_LAST=0, o_DATA=0, o_OVR=0, o_PHERR=0, o_STOP_n=1.
  - Reset mid-byte discards the partial byte.
- Sample side: acts only on edges where i_CEN_n=0.
  - i_ROT8 all-zero: idle; no state change.
  - i_ROT8 one-hot at bit k<7: SR[k]<=i_SDATA, M[k]<=1.
  - i_ROT8 one-hot at bit 7 with M==7'h7F: form byte B={i_SDATA, SR[6:0]} and attempt a push of {LAST=(FC==FRAME_LEN-1), B}. M<=0. FC<=(FC==FRAME_LEN-1)?0:FC+1.
  - FC advances on every completed byte, including dropped ones, so framing stays aligned with the media.
  - i_ROT8 one-hot at bit 7 with M!=7'h7F: no push; M<=0; o_PHERR<=1; FC unchanged.
  - i_ROT8 with more than one bit set: o_PHERR<=1; M<=0; SR unchanged; no push.
- Push latency: the pushed byte becomes visible at o_DATA/o_VALID on the edge after the phase-7 sample edge. Outputs are registered from FIFO storage.
- Pop: acts on any i_CLK edge (not CEN-gated) where o_VALID=1 and i_READY=1. The head advances and the next entry appears the following cycle. o_DATA/o_LAST hold while o_VALID=1 and i_READY=0.
- FIFO count rules:
  - Push and pop on the same edge: both occur, count unchanged. This holds when full: the push is accepted and there is no overrun.
  - Push without pop while count==DEPTH: byte dropped, o_OVR<=1, FIFO unchanged.
  - Pointers wrap modulo DEPTH.
- o_STOP_n = ~(count >= DEPTH-1), combinational from the registered count.
  - A rotation already in flight completes, so one slot is always reserved for it.
  - Overrun therefore occurs only if the consumer also stalls while the rotator ignores stop.
- Flags:
  - i_CLR=1 clears o_OVR and o_PHERR on the next edge.
  - A set event on the same edge as i_CLR wins; the flag stays 1.
- i_CEN_n high freezes the sample side but not the pop side.

Test Plan:
- Clean byte: drive phases 0..7 with i_SDATA=1,0,1,0,0,1,0,1 on CEN cycles -> o_DATA=8'hA5, o_VALID=1 on the edge after phase 7, o_LAST=0, flags 0.
- Back-pressure: DEPTH=2, i_READY=0, stream bytes 8'h11, 8'h22 -> o_STOP_n falls after the first push. The rotator halts, count ends at 2 with head 8'h11, o_OVR=0. i_READY=1 for 2 cycles yields 8'h11 then 8'h22.
- Overrun: DEPTH=2, i_READY=0, and ignore o_STOP_n by feeding a 3rd byte 8'h33 -> o_OVR=1, FIFO still holds 8'h11, 8'h22. i_CLR pulse -> o_OVR=0.
- Simultaneous push/pop when full: count=2, i_READY=1 on the phase-7 push edge -> count stays 2, no overrun, order 8'h22, 8'h33.
- Phase errors: i_ROT8=8'h03 mid-byte -> o_PHERR=1 and no push. Next rotation starting at phase 1 (phase 0 skipped) -> no push at phase 7, o_PHERR stays 1. A subsequent full rotation pushes normally.
- Framing and reset: FRAME_LEN=4, stream 5 bytes -> o_LAST=1 only on the 4th, 5th has o_LAST=0. Assert i_RST_n=0 at phase 3 -> o_VALID=0 immediately, o_STOP_n=1; the next full rotation yields a correct byte with FC=0.

Source files
------------

// File: rtl/submdl_deser8.sv
// submdl_deser8: serial-to-byte assembler driven by an 8-phase one-hot rotator.
// Bits are packed LSB first. Completed bytes are queued in a small FIFO with a
// valid/ready output, and the rotator is held off while the FIFO is near full.
// Frame position, overrun and phase errors are tracked alongside the data.
module submdl_deser8 #(
  parameter int DEPTH     = 2,
  parameter int FRAME_LEN = 64
) (
  input  logic       i_CLK,
  input  logic       i_RST_n,
  input  logic       i_CEN_n,
  input  logic [7:0] i_ROT8,
  input  logic       i_SDATA,
  output logic       o_STOP_n,
  output logic [7:0] o_DATA,
  output logic       o_LAST,
  output logic       o_VALID,
  input  logic       i_READY,
  input  logic       i_CLR,
  output logic       o_OVR,
  output logic       o_PHERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX_C   = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FC_LAST_C   = FW'(FRAME_LEN - 1);

  // Byte assembly state: data bits for phases 0..6 and which of them were seen.
  logic [6:0]    sr_reg, sr_next;
  logic [6:0]    m_reg, m_next;
  logic [FW-1:0] fc_reg;

  // FIFO storage: {last, byte} per entry.
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_inc, wr_inc, rd_sel;
  logic [CW-1:0] count_reg, count_next, vis_next;

  logic          valid_reg, last_reg, ovr_reg, pherr_reg;
  logic [7:0]    data_reg;

  logic          sample, rot_multi, byte_done, phase_err;
  logic          pop, push_ok, ovr_evt;
  logic [8:0]    push_word;

  // Phase decode; an all-zero vector is idle, a multi-hot vector is an error.
  assign sample    = ~i_CEN_n && (i_ROT8 != 8'h00);
  assign rot_multi = |(i_ROT8 & (i_ROT8 - 8'd1));
  assign byte_done = sample && !rot_multi && i_ROT8[7] && (m_reg == 7'h7F);
  assign phase_err = sample && (rot_multi || (i_ROT8[7] && (m_reg != 7'h7F)));
  assign push_word = {(fc_reg == FC_LAST_C), i_SDATA, sr_reg};

  // Pop is not gated by the clock enable; a push into a full FIFO is still
  // accepted when a pop frees the head slot on the same edge.
  assign pop     = valid_reg && i_READY;
  assign push_ok = byte_done && ((count_reg != DEPTH_C) || pop);
  assign ovr_evt = byte_done && (count_reg == DEPTH_C) && !pop;

  assign rd_inc = (rd_ptr_reg == PTR_MAX_C) ? '0 : rd_ptr_reg + PW'(1);
  assign wr_inc = (wr_ptr_reg == PTR_MAX_C) ? '0 : wr_ptr_reg + PW'(1);
  assign rd_sel = pop ? rd_inc : rd_ptr_reg;

  // Entries written before this edge, minus the one being popped, are what the
  // output register may show next; a byte pushed on this edge appears one later.
  assign vis_next = count_reg - CW'(pop);

  // Per-phase bit capture; phase 7 or a multi-hot vector restarts the byte.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bit
      assign sr_next[gi] = (sample && !rot_multi && i_ROT8[gi]) ? i_SDATA : sr_reg[gi];
      assign m_next[gi]  = (sample && (rot_multi || i_ROT8[7])) ? 1'b0 :
                           (sample && i_ROT8[gi])               ? 1'b1 : m_reg[gi];
    end
  endgenerate

  // FIFO occupancy after this edge's push and pop.
  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push_ok && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Sample-side state: shift register, seen mask and frame counter.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sr_reg <= '0;
      m_reg  <= '0;
      fc_reg <= '0;
    end else begin
      sr_reg <= sr_next;
      m_reg  <= m_next;
      if (byte_done) begin
        fc_reg <= (fc_reg == FC_LAST_C) ? '0 : fc_reg + FW'(1);
      end
    end
  end

  // FIFO storage write; no reset so it can map onto distributed RAM.
  always_ff @(posedge i_CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  // FIFO pointers, count and the registered head outputs.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= 8'h00;
      last_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_inc;
      end
      if (pop) begin
        rd_ptr_reg <= rd_inc;
      end
      count_reg <= count_next;
      valid_reg <= (vis_next != '0);
      if (vis_next != '0) begin
        data_reg <= mem[rd_sel][7:0];
        last_reg <= mem[rd_sel][8];
      end
    end
  end

  // Sticky flags; a set event on the same edge as a clear keeps the flag high.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      ovr_reg   <= 1'b0;
      pherr_reg <= 1'b0;
    end else begin
      if (ovr_evt) begin
        ovr_reg <= 1'b1;
      end else if (i_CLR) begin
        ovr_reg <= 1'b0;
      end
      if (phase_err) begin
        pherr_reg <= 1'b1;
      end else if (i_CLR) begin
        pherr_reg <= 1'b0;
      end
    end
  end

  // One slot stays reserved for a rotation that is already in flight.
  assign o_STOP_n = ~(count_reg >= NEAR_FULL_C);
  assign o_DATA   = data_reg;
  assign o_LAST   = last_reg;
  assign o_VALID  = valid_reg;
  assign o_OVR    = ovr_reg;
  assign o_PHERR  = pherr_reg;

endmodule

// File: tb/tb_submdl_deser8.sv
// Testbench for submdl_deser8: a directed vector table, hand-written corner
// sequences and a randomized run, all checked every cycle against a queue-based
// reference model of the byte assembler and FIFO.
module tb_submdl_deser8;

  localparam int DEPTH     = 2;
  localparam int FRAME_LEN = 4;

  logic       i_CLK   = 1'b0;
  logic       i_RST_n = 1'b1;
  logic       i_CEN_n = 1'b1;
  logic [7:0] i_ROT8  = 8'h00;
  logic       i_SDATA = 1'b0;
  logic       i_READY = 1'b0;
  logic       i_CLR   = 1'b0;
  logic       o_STOP_n, o_LAST, o_VALID, o_OVR, o_PHERR;
  logic [7:0] o_DATA;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [8:0] m_q[$];
  logic [8:0] m_head;
  bit         m_valid, m_ovr, m_pherr;
  int         m_fc;
  bit   [6:0] m_have, m_bits;

  typedef struct {
    logic       cen_n;
    logic [7:0] rot;
    logic       sd;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic       stop_n;
  } vec_t;

  vec_t tbl[11];

  submdl_deser8 #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_CEN_n (i_CEN_n),
    .i_ROT8  (i_ROT8),
    .i_SDATA (i_SDATA),
    .o_STOP_n(o_STOP_n),
    .o_DATA  (o_DATA),
    .o_LAST  (o_LAST),
    .o_VALID (o_VALID),
    .i_READY (i_READY),
    .i_CLR   (i_CLR),
    .o_OVR   (o_OVR),
    .o_PHERR (o_PHERR)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge: bits collect per phase, a complete phase-7 sample
  // yields a byte, the FIFO is a queue, and a byte pushed on this edge only
  // becomes visible at the head one edge later.
  task automatic model_edge(input logic cen_n, input logic [7:0] rot, input logic sd,
                            input logic rdy, input logic clr);
    bit         pop, done, ovr_e, ph_e;
    logic [8:0] ent;
    int         older;
    pop = m_valid && rdy;
    done = 0; ovr_e = 0; ph_e = 0; ent = '0;
    if (!cen_n && rot != 8'h00) begin
      if ($countones(rot) > 1) begin
        ph_e = 1;
        m_have = '0;
      end else if (rot[7]) begin
        if (m_have == 7'h7F) begin
          done = 1;
          ent = {(m_fc == FRAME_LEN - 1), sd, m_bits};
          m_fc = (m_fc + 1) % FRAME_LEN;
        end else begin
          ph_e = 1;
        end
        m_have = '0;
      end else begin
        for (int k = 0; k < 7; k++) begin
          if (rot[k]) begin
            m_bits[k] = sd;
            m_have[k] = 1'b1;
          end
        end
      end
    end
    if (pop) begin
      $display("pop data=%02h last=%0d", m_head[7:0], m_head[8]);
      void'(m_q.pop_front());
    end
    older = m_q.size();
    if (done) begin
      if (m_q.size() < DEPTH) m_q.push_back(ent);
      else ovr_e = 1;
    end
    m_valid = (older > 0);
    if (m_valid) m_head = m_q[0];
    if (ovr_e) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (ph_e) m_pherr = 1;
    else if (clr) m_pherr = 0;
  endtask

  // Drive one cycle (from a falling edge), update the model, compare outputs.
  task automatic step(input logic cen_n, input logic [7:0] rot, input logic sd,
                      input logic rdy, input logic clr);
    i_CEN_n = cen_n; i_ROT8 = rot; i_SDATA = sd; i_READY = rdy; i_CLR = clr;
    @(posedge i_CLK);
    model_edge(cen_n, rot, sd, rdy, clr);
    @(negedge i_CLK);
    chk("valid", 32'(o_VALID), 32'(m_valid));
    if (m_valid) chk("head", 32'({o_LAST, o_DATA}), 32'(m_head));
    chk("stop_n", 32'(o_STOP_n), (m_q.size() >= DEPTH - 1) ? 32'd0 : 32'd1);
    chk("ovr", 32'(o_OVR), 32'(m_ovr));
    chk("pherr", 32'(o_PHERR), 32'(m_pherr));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy7);
    for (int p = 0; p < 8; p++) begin
      step(1'b0, 8'(1 << p), b[p], (p == 7) ? rdy7 : 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset applied at a falling edge; outputs must clear at once.
  task automatic do_reset();
    i_CEN_n = 1'b1; i_ROT8 = 8'h00; i_READY = 1'b0; i_CLR = 1'b0;
    i_RST_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_VALID), 32'd0);
    chk("rst_data", 32'(o_DATA), 32'd0);
    chk("rst_last", 32'(o_LAST), 32'd0);
    chk("rst_ovr", 32'(o_OVR), 32'd0);
    chk("rst_pherr", 32'(o_PHERR), 32'd0);
    chk("rst_stop_n", 32'(o_STOP_n), 32'd1);
    m_q.delete();
    m_head = '0; m_valid = 0; m_ovr = 0; m_pherr = 0;
    m_fc = 0; m_have = '0; m_bits = '0;
    @(negedge i_CLK);
    i_RST_n = 1'b1;
  endtask

  initial begin
    logic       cen_n, rdy;
    logic [7:0] rot;
    int         ph, r;

    // Clean byte 8'hA5 (LSB first), with one CEN-high cycle that must be ignored.
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};

    #2;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].cen_n, tbl[i].rot, tbl[i].sd, tbl[i].rdy, 1'b0);
      chk("tbl_valid", 32'(o_VALID), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk("tbl_data", 32'(o_DATA), 32'(tbl[i].data));
        chk("tbl_last", 32'(o_LAST), 32'd0);
      end
      chk("tbl_stop_n", 32'(o_STOP_n), 32'(tbl[i].stop_n));
      chk("tbl_flags", 32'({o_OVR, o_PHERR}), 32'd0);
    end

    // Back-pressure, then overrun by ignoring stop, then drain and clear.
    do_reset();
    send_byte(8'h11, 1'b0);
    chk("bp_stop_after_first", 32'(o_STOP_n), 32'd0);
    send_byte(8'h22, 1'b0);
    idle(1'b0);
    chk("bp_head", 32'(o_DATA), 32'h11);
    chk("bp_ovr", 32'(o_OVR), 32'd0);
    send_byte(8'h33, 1'b0);
    idle(1'b0);
    chk("ovr_set", 32'(o_OVR), 32'd1);
    chk("ovr_head", 32'(o_DATA), 32'h11);
    idle(1'b1);
    chk("ovr_second", 32'(o_DATA), 32'h22);
    idle(1'b1);
    chk("ovr_drained", 32'(o_VALID), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(o_OVR), 32'd0);

    // Push and pop on the same edge while full.
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("pp_no_ovr", 32'(o_OVR), 32'd0);
    chk("pp_head1", 32'(o_DATA), 32'h22);
    idle(1'b1);
    chk("pp_head2", 32'(o_DATA), 32'h33);
    idle(1'b1);

    // Phase errors: multi-hot mid-byte, then a rotation missing phase 0.
    do_reset();
    for (int p = 0; p < 3; p++) step(1'b0, 8'(1 << p), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("pherr_multi", 32'(o_PHERR), 32'd1);
    for (int p = 1; p < 8; p++) step(1'b0, 8'(1 << p), 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("pherr_nopush", 32'(o_VALID), 32'd0);
    chk("pherr_sticky", 32'(o_PHERR), 32'd1);
    send_byte(8'h5A, 1'b0);
    idle(1'b0);
    chk("pherr_recover", 32'(o_DATA), 32'h5A);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("pherr_clr", 32'(o_PHERR), 32'd0);

    // Framing: the 4th byte is last, the 5th starts a new frame.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h40 + i), 1'b0);
      idle(1'b0);
      chk("frame_last", 32'(o_LAST), (i == 3) ? 32'd1 : 32'd0);
      idle(1'b1);
    end

    // Reset in the middle of a byte with data queued.
    send_byte(8'hC3, 1'b0);
    idle(1'b0);
    for (int p = 0; p < 4; p++) step(1'b0, 8'(1 << p), 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'hC3 ^ i), 1'b0);
      idle(1'b0);
      chk("post_rst_data", 32'(o_DATA), 32'(8'hC3 ^ i));
      chk("post_rst_last", 32'(o_LAST), (i == 3) ? 32'd1 : 32'd0);
      idle(1'b1);
    end

    // Randomized run: a rotator that mostly honours stop, plus glitches.
    ph = 0;
    for (int n = 0; n < 600; n++) begin
      cen_n = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 99);
      if (r < 5) begin
        rot = 8'($urandom_range(1, 255));
      end else if (r < 12) begin
        rot = 8'h00;
      end else if (ph == 0 && !o_STOP_n && r < 70) begin
        rot = 8'h00;
      end else begin
        rot = 8'(1 << ph);
        if (!cen_n) ph = (ph + 1) % 8;
      end
      rdy = ($urandom_range(0, 2) == 0);
      step(cen_n, rot, 1'($urandom_range(0, 1)), rdy, ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
